// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin pop scheduler sharing one downstream push port among a FIFO bank.
// Programs FIFO thresholds, returns popped words two cycles later, traps errors.
module fifo_rr_read_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int DATA_SIZE = 6,
    parameter int SEL_W     = 2
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           init,
    input  logic [DATA_SIZE-1:0]           cfg_almost_full,
    input  logic [DATA_SIZE-1:0]           cfg_almost_empty,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS-1:0]           fifo_error,
    input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
    input  logic                           down_pause,
    output logic [DATA_SIZE-1:0]           umb_almost_full,
    output logic [DATA_SIZE-1:0]           umb_almost_empty,
    output logic [NUM_FIFOS-1:0]           read,
    output logic                           push_out,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic [SEL_W-1:0]               grant_id,
    output logic                           idle,
    output logic                           error_out,
    output logic [7:0]                     push_count
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACTIVE,
        ERROR
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     rd_id;
    logic                 fetch_vld;
    logic [SEL_W-1:0]     fetch_id;
    logic [NUM_FIFOS-1:0] eligible;
    logic                 grant_vld;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     cand;
    logic                 any_ready;
    logic                 any_error;
    logic                 in_flight;
    logic [DATA_SIZE-1:0] words [NUM_FIFOS];

    function automatic int wrap(input int v);
        return (v >= NUM_FIFOS) ? v - NUM_FIFOS : v;
    endfunction

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_words
        assign words[g] = fifo_data[g*DATA_SIZE +: DATA_SIZE];
    end

    // The FIFO popped last cycle still shows its pre-pop empty flag.
    assign eligible  = ~fifo_empty & ~read;
    assign any_ready = ~&fifo_empty;
    assign any_error = |fifo_error;
    assign in_flight = (|read) | fetch_vld;
    assign idle      = (state == IDLE);
    assign error_out = (state == ERROR);

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int off = NUM_FIFOS - 1; off >= 0; off--) begin
            cand = SEL_W'(wrap(int'(rr_ptr) + off));
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            state            <= INIT;
            rr_ptr           <= '0;
            rd_id            <= '0;
            fetch_vld        <= 1'b0;
            fetch_id         <= '0;
            read             <= '0;
            push_out         <= 1'b0;
            data_out         <= '0;
            grant_id         <= '0;
            push_count       <= '0;
            umb_almost_full  <= '0;
            umb_almost_empty <= '0;
        end else begin
            read      <= '0;
            fetch_vld <= 1'b0;
            push_out  <= 1'b0;
            if (state != INIT && any_error) begin
                state <= ERROR;
            end else begin
                fetch_vld <= |read;
                fetch_id  <= rd_id;
                push_out  <= fetch_vld;
                if (fetch_vld) begin
                    data_out   <= words[fetch_id];
                    grant_id   <= fetch_id;
                    push_count <= push_count + 8'd1;
                end
                unique case (state)
                    INIT: begin
                        if (init) begin
                            umb_almost_full  <= cfg_almost_full;
                            umb_almost_empty <= cfg_almost_empty;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (init) begin
                            state <= INIT;
                        end else if (any_ready && !down_pause) begin
                            state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (!down_pause && grant_vld) begin
                            read   <= NUM_FIFOS'(1) << grant;
                            rd_id  <= grant;
                            rr_ptr <= SEL_W'(wrap(int'(grant) + 1));
                        end else if (!any_ready && !in_flight) begin
                            state <= IDLE;
                        end
                    end
                    ERROR: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Randomized bench for fifo_rr_read_arbiter: behavioural FIFO bank, rule-level
// arbiter model and a push scoreboard drained by an independent monitor.
module tb_fifo_rr_read_arbiter;

    localparam int NF = 4;
    localparam int DW = 6;
    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_ACT  = 2;
    localparam int M_ERR  = 3;

    logic            clk = 1'b0;
    logic            reset_L;
    logic            init;
    logic [DW-1:0]   cfg_af;
    logic [DW-1:0]   cfg_ae;
    logic [NF-1:0]   fifo_empty;
    logic [NF-1:0]   fifo_error;
    logic [NF*DW-1:0] fifo_data;
    logic            down_pause;
    logic [DW-1:0]   umb_almost_full;
    logic [DW-1:0]   umb_almost_empty;
    logic [NF-1:0]   read;
    logic            push_out;
    logic [DW-1:0]   data_out;
    logic [1:0]      grant_id;
    logic            idle;
    logic            error_out;
    logic [7:0]      push_count;

    fifo_rr_read_arbiter #(.NUM_FIFOS(NF), .DATA_SIZE(DW), .SEL_W(2)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .init             (init),
        .cfg_almost_full  (cfg_af),
        .cfg_almost_empty (cfg_ae),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .fifo_data        (fifo_data),
        .down_pause       (down_pause),
        .umb_almost_full  (umb_almost_full),
        .umb_almost_empty (umb_almost_empty),
        .read             (read),
        .push_out         (push_out),
        .data_out         (data_out),
        .grant_id         (grant_id),
        .idle             (idle),
        .error_out        (error_out),
        .push_count       (push_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int word;
        int due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fq [NF][$];
    logic [DW-1:0] fdata [NF];
    logic [NF-1:0] pend_rd;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    int m_state, ptr, last_pop_cyc, last_pop_id;
    int exp_read, exp_idle, exp_err, exp_af, exp_ae;

    for (genvar g = 0; g < NF; g++) begin : g_data
        assign fifo_data[g*DW +: DW] = fdata[g];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state      = M_INIT;
        ptr          = 0;
        last_pop_cyc = -10;
        last_pop_id  = 0;
        exp_read     = 0;
        exp_idle     = 0;
        exp_err      = 0;
        exp_af       = 0;
        exp_ae       = 0;
        sb.delete();
    endtask

    // Predicts what the arbiter does at the coming clock edge.
    task automatic model_step(input bit rst, input bit ini, input bit pz,
                              input logic [NF-1:0] err);
        int   ne [NF];
        int   g;
        exp_t e;
        for (int i = 0; i < NF; i++) ne[i] = (fq[i].size() > 0) ? 1 : 0;
        exp_read = 0;
        if (rst) begin
            model_reset();
        end else if (m_state != M_INIT && err != '0) begin
            m_state = M_ERR;
            sb.delete();
            last_pop_cyc = -10;
        end else begin
            case (m_state)
                M_INIT: begin
                    if (ini) begin
                        exp_af = int'(cfg_af);
                        exp_ae = int'(cfg_ae);
                    end else begin
                        m_state = M_IDLE;
                    end
                end
                M_IDLE: begin
                    if (ini) m_state = M_INIT;
                    else if (fifo_empty != '1 && !pz) m_state = M_ACT;
                end
                M_ACT: begin
                    if (last_pop_cyc == cyc) ne[last_pop_id] = 0;
                    g = -1;
                    if (!pz)
                        for (int k = 0; k < NF; k++)
                            if (g < 0 && ne[(ptr + k) % NF] != 0) g = (ptr + k) % NF;
                    if (g >= 0) begin
                        exp_read     = 1 << g;
                        ptr          = (g + 1) % NF;
                        e.id         = g;
                        e.word       = int'(fq[g][0]);
                        e.due        = cyc + 3;
                        sb.push_back(e);
                        last_pop_cyc = cyc + 1;
                        last_pop_id  = g;
                    end else if (fifo_empty == '1 && last_pop_cyc < cyc - 1) begin
                        m_state = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        exp_idle = (m_state == M_IDLE) ? 1 : 0;
        exp_err  = (m_state == M_ERR) ? 1 : 0;
    endtask

    task automatic step(input bit rst, input bit ini, input bit pz,
                        input logic [NF-1:0] err, input int fill_pct);
        @(negedge clk);
        chk("read", int'(read), exp_read);
        chk("idle", int'(idle), exp_idle);
        chk("error_out", int'(error_out), exp_err);
        chk("umb_almost_full", int'(umb_almost_full), exp_af);
        chk("umb_almost_empty", int'(umb_almost_empty), exp_ae);
        for (int i = 0; i < NF; i++)
            if (pend_rd[i] && fq[i].size() > 0) fdata[i] = fq[i].pop_front();
        pend_rd = rst ? '0 : read;
        for (int i = 0; i < NF; i++)
            if (fq[i].size() < 8 && $urandom_range(0, 99) < fill_pct)
                fq[i].push_back(DW'($urandom));
        reset_L    = rst;
        init       = ini;
        down_pause = pz;
        fifo_error = err;
        for (int i = 0; i < NF; i++) fifo_empty[i] = (fq[i].size() == 0);
        model_step(rst, ini, pz, err);
    endtask

    task automatic program_cfg();
        repeat (3) step(0, 1, 0, '0, 0);
        step(0, 0, 0, '0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reset_L) begin
                exp_cnt = 0;
                chk("push_in_reset", int'(push_out), 0);
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_cnt = (exp_cnt + 1) % 256;
                chk("push_out", int'(push_out), 1);
                chk("data_out", int'(data_out), sb[0].word);
                chk("grant_id", int'(grant_id), sb[0].id);
                void'(sb.pop_front());
            end else begin
                chk("push_out", int'(push_out), 0);
            end
            chk("push_count", int'(push_count), exp_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev;
        int tries;
        reset_L    = 1'b1;
        init       = 1'b0;
        cfg_af     = '0;
        cfg_ae     = '0;
        down_pause = 1'b0;
        fifo_error = '0;
        fifo_empty = '1;
        pend_rd    = '0;
        for (int i = 0; i < NF; i++) fdata[i] = '0;
        model_reset();

        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        cfg_af = 6'd12;
        cfg_ae = 6'd2;
        program_cfg();
        step(0, 0, 0, '0, 0);

        for (int i = 0; i < NF; i++) fq[i].push_back(DW'(i + 1));
        repeat (10) step(0, 0, 0, '0, 0);
        chk("sweep_push_count", int'(push_count), 4);

        fq[2].push_back(6'h15);
        fq[2].push_back(6'h2a);
        fq[2].push_back(6'h3f);
        repeat (10) step(0, 0, 0, '0, 0);
        chk("single_push_count", int'(push_count), 7);
        chk("single_idle", int'(idle), 1);

        repeat (4) begin
            fq[0].push_back(DW'($urandom));
            fq[1].push_back(DW'($urandom));
        end
        tries = 0;
        while (exp_read == 0 && tries < 10) begin
            step(0, 0, 0, '0, 0);
            tries++;
        end
        chk("pause_setup", (exp_read != 0) ? 1 : 0, 1);
        repeat (4) step(0, 0, 1, '0, 0);
        repeat (12) step(0, 0, 0, '0, 0);

        for (int n = 0; n < 400; n++)
            step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                 '0, (n / 50) * 12 + 5);
        repeat (30) step(0, 0, 0, '0, 0);

        for (int i = 0; i < NF; i++) repeat (4) fq[i].push_back(DW'($urandom));
        tries = 0;
        while (!(m_state == M_ACT && exp_read != 0) && tries < 20) begin
            step(0, 0, 0, '0, 0);
            tries++;
        end
        chk("error_setup", m_state, M_ACT);
        step(0, 0, 0, 4'b0010, 0);
        repeat (8) step(0, 0, 0, '0, 50);

        step(1, 0, 0, '0, 0);
        program_cfg();
        for (int i = 0; i < NF; i++) repeat (4) fq[i].push_back(DW'($urandom));
        prev  = 1'b0;
        tries = 0;
        while (!(prev && exp_read != 0) && tries < 30) begin
            prev = (exp_read != 0);
            step(0, 0, 0, '0, 0);
            tries++;
        end
        chk("reset_setup", (prev && exp_read != 0) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        reset_L = 1'b1;
        model_reset();
        #1;
        chk("rst_read", int'(read), 0);
        chk("rst_push_out", int'(push_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_push_count", int'(push_count), 0);
        chk("rst_umb_af", int'(umb_almost_full), 0);
        chk("rst_umb_ae", int'(umb_almost_empty), 0);
        chk("rst_idle", int'(idle), 0);
        step(1, 0, 0, '0, 0);
        repeat (4) step(0, 1, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        for (int n = 0; n < 150; n++)
            step(0, 0, ($urandom_range(0, 5) == 0), '0, 40);
        repeat (30) step(0, 0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
